// File: rtl/operand_fetch_unit_pkg.sv
// rtl/operand_fetch_unit_pkg.sv - shared constants and forwarding-source enum for the operand fetch unit
// Contents:
//   OFU_DATA_W, OFU_REG_COUNT, OFU_ADDR_W : default operand width, register count, index width
//   fwd_src_t                             : which source supplied an operand (debug/coverage)
package operand_fetch_unit_pkg;

    localparam int OFU_DATA_W    = 16;
    localparam int OFU_REG_COUNT = 8;
    localparam int OFU_ADDR_W    = 3;

    typedef enum logic [1:0] {
        FWD_EX  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_RF  = 2'd3
    } fwd_src_t;

endpackage

// File: rtl/operand_resolver.sv
// rtl/operand_resolver.sv - combinational priority mux resolving one source operand
// Ports:
//   rd_addr                     : register index being read
//   ex_en/ex_addr/ex_data       : EX/MEM result in flight (youngest, highest priority)
//   mem_en/mem_addr/mem_data    : MEM/WB result in flight
//   wb_en/wb_addr/wb_data       : write-back landing this cycle (same-cycle bypass)
//   rf_data                     : register array contents at rd_addr
//   rd_data                     : resolved operand value
module operand_resolver
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W = OFU_DATA_W,
    parameter int ADDR_W = OFU_ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              ex_en,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] rd_data
);

    fwd_src_t src;

    // Youngest in-flight result wins when several sources target the same index.
    always_comb begin
        src = FWD_RF;
        if (ex_en && (ex_addr == rd_addr)) begin
            src = FWD_EX;
        end else if (mem_en && (mem_addr == rd_addr)) begin
            src = FWD_MEM;
        end else if (wb_en && (wb_addr == rd_addr)) begin
            src = FWD_WB;
        end
    end

    always_comb begin
        rd_data = rf_data;
        case (src)
            FWD_EX:  rd_data = ex_data;
            FWD_MEM: rd_data = mem_data;
            FWD_WB:  rd_data = wb_data;
            default: rd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - register file, hazard forwarding and ID/EX operand registers
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   id_valid, rs_addr, rt_addr  : decode slot and its two source indices
//   a_sel_in                    : operand A taken from the input-port register
//   stall, flush                : ID/EX hold and bubble insert (flush wins)
//   wb_en/wb_addr/wb_data       : register-file write port
//   ex_fwd_*, mem_fwd_*         : in-flight results for forwarding
//   in_port_en, in_port_data    : external input port capture
//   op_valid, op_a, op_b        : registered operands for EX
//   op_rs, op_rt                : registered source indices for EX-side hazard logic
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W    = OFU_DATA_W,
    parameter int REG_COUNT = OFU_REG_COUNT,
    parameter int ADDR_W    = OFU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              a_sel_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_fwd_en,
    input  logic [ADDR_W-1:0] ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_fwd_en,
    input  logic [ADDR_W-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              in_port_en,
    input  logic [DATA_W-1:0] in_port_data,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rs,
    output logic [ADDR_W-1:0] op_rt
);

    logic [DATA_W-1:0] rf_q [REG_COUNT];
    logic [DATA_W-1:0] rf_d [REG_COUNT];
    logic [DATA_W-1:0] in_port_q, in_port_d;
    logic              op_valid_q, op_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [ADDR_W-1:0] op_rs_q, op_rs_d;
    logic [ADDR_W-1:0] op_rt_q, op_rt_d;
    logic              a_sel_q, a_sel_d;

    logic [ADDR_W-1:0] rd_rs, rd_rt;
    logic              rd_a_sel;
    logic [DATA_W-1:0] res_a, res_b, port_val, val_a;

    // During a stall the held indices are re-read so the held operands track
    // any write or forward that arrives while EX is blocked.
    assign rd_rs    = stall ? op_rs_q : rs_addr;
    assign rd_rt    = stall ? op_rt_q : rt_addr;
    assign rd_a_sel = stall ? a_sel_q : a_sel_in;

    // Input-port value with same-cycle capture bypass.
    assign port_val = in_port_en ? in_port_data : in_port_q;

    operand_resolver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_res_a (
        .rd_addr  (rd_rs),
        .ex_en    (ex_fwd_en),
        .ex_addr  (ex_fwd_addr),
        .ex_data  (ex_fwd_data),
        .mem_en   (mem_fwd_en),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rf_data  (rf_q[rd_rs]),
        .rd_data  (res_a)
    );

    operand_resolver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_res_b (
        .rd_addr  (rd_rt),
        .ex_en    (ex_fwd_en),
        .ex_addr  (ex_fwd_addr),
        .ex_data  (ex_fwd_data),
        .mem_en   (mem_fwd_en),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rf_data  (rf_q[rd_rt]),
        .rd_data  (res_b)
    );

    // The input port bypasses all forwarding.
    assign val_a = rd_a_sel ? port_val : res_a;

    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
        in_port_d = port_val;

        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_rs_d    = op_rs_q;
        op_rt_d    = op_rt_q;
        a_sel_d    = a_sel_q;

        if (flush) begin
            op_valid_d = 1'b0;
            op_a_d     = '0;
            op_b_d     = '0;
            op_rs_d    = '0;
            op_rt_d    = '0;
            a_sel_d    = 1'b0;
        end else if (stall) begin
            op_a_d = val_a;
            op_b_d = res_b;
        end else begin
            op_valid_d = id_valid;
            op_a_d     = val_a;
            op_b_d     = res_b;
            op_rs_d    = rs_addr;
            op_rt_d    = rt_addr;
            a_sel_d    = a_sel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
            in_port_q  <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rs_q    <= '0;
            op_rt_q    <= '0;
            a_sel_q    <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            in_port_q  <= in_port_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_rs_q    <= op_rs_d;
            op_rt_q    <= op_rt_d;
            a_sel_q    <= a_sel_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_rs    = op_rs_q;
    assign op_rt    = op_rt_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed table-driven bench for operand_fetch_unit
module tb_operand_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, id_valid, a_sel_in, stall, flush;
    logic [2:0]  rs_addr, rt_addr, wb_addr, ex_fwd_addr, mem_fwd_addr;
    logic        wb_en, ex_fwd_en, mem_fwd_en, in_port_en;
    logic [15:0] wb_data, ex_fwd_data, mem_fwd_data, in_port_data;
    logic        op_valid;
    logic [15:0] op_a, op_b;
    logic [2:0]  op_rs, op_rt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .a_sel_in     (a_sel_in),
        .stall        (stall),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_fwd_en    (ex_fwd_en),
        .ex_fwd_addr  (ex_fwd_addr),
        .ex_fwd_data  (ex_fwd_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .in_port_en   (in_port_en),
        .in_port_data (in_port_data),
        .op_valid     (op_valid),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_rs        (op_rs),
        .op_rt        (op_rt)
    );

    typedef struct packed {
        logic        rst;
        logic        idv;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic        asel;
        logic        stall;
        logic        flush;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        ex_en;
        logic [2:0]  ex_addr;
        logic [15:0] ex_data;
        logic        mem_en;
        logic [2:0]  mem_addr;
        logic [15:0] mem_data;
        logic        ip_en;
        logic [15:0] ip_data;
        logic        e_valid;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [2:0]  e_rs;
        logic [2:0]  e_rt;
    } vec_t;

    vec_t vecs [64];
    int   nv = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " op_valid"}, 16'(op_valid), 16'(v.e_valid));
        chk({tag, " op_a"}, op_a, v.e_a);
        chk({tag, " op_b"}, op_b, v.e_b);
        chk({tag, " op_rs"}, 16'(op_rs), 16'(v.e_rs));
        chk({tag, " op_rt"}, 16'(op_rt), 16'(v.e_rt));
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; id_valid = v.idv; rs_addr = v.rs; rt_addr = v.rt;
        a_sel_in = v.asel; stall = v.stall; flush = v.flush;
        wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
        ex_fwd_en = v.ex_en; ex_fwd_addr = v.ex_addr; ex_fwd_data = v.ex_data;
        mem_fwd_en = v.mem_en; mem_fwd_addr = v.mem_addr; mem_fwd_data = v.mem_data;
        in_port_en = v.ip_en; in_port_data = v.ip_data;
    endtask

    // Apply one record on the falling edge, sample just after the rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        chk_all(tag, v);
    endtask

    initial begin
        vec_t v;
        v = '0;
        drive(v);

        // rst idv rs rt asel stall flush | wb | ex | mem | ip | expected valid a b rs rt
        vecs[nv] = '{1'b1,1'b1,3'd0,3'd0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000,3'd0,3'd0}; nv++;
        vecs[nv] = '{1'b1,1'b1,3'd1,3'd2,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000,3'd0,3'd0}; nv++;
        for (int i = 0; i < 8; i++) begin
            vecs[nv] = '0;
            vecs[nv].idv = 1'b1;
            vecs[nv].rs = 3'(i);
            vecs[nv].rt = 3'(7 - i);
            vecs[nv].e_valid = 1'b1;
            vecs[nv].e_rs = 3'(i);
            vecs[nv].e_rt = 3'(7 - i);
            nv++;
        end
        // write-back bypass then array read
        vecs[nv] = '{1'b0,1'b1,3'd3,3'd0,1'b0,1'b0,1'b0, 1'b1,3'd3,16'hBEEF, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'hBEEF,16'h0000,3'd3,3'd0}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd3,3'd3,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'hBEEF,16'hBEEF,3'd3,3'd3}; nv++;
        // forward priority ex > mem > wb > array
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd2,1'b0,1'b0,1'b0, 1'b1,3'd2,16'h3333, 1'b1,3'd2,16'h1111, 1'b1,3'd2,16'h2222, 1'b0,16'h0000, 1'b1,16'h1111,16'h1111,3'd2,3'd2}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd2,1'b0,1'b0,1'b0, 1'b1,3'd2,16'h3333, 1'b0,3'd0,16'h0000, 1'b1,3'd2,16'h2222, 1'b0,16'h0000, 1'b1,16'h2222,16'h2222,3'd2,3'd2}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd2,1'b0,1'b0,1'b0, 1'b1,3'd2,16'h3333, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h3333,16'h3333,3'd2,3'd2}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd1,3'd4,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b1,3'd1,16'h0101, 1'b1,3'd4,16'h0404, 1'b0,16'h0000, 1'b1,16'h0101,16'h0404,3'd1,3'd4}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd1,3'd4,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0000,16'h0000,3'd1,3'd4}; nv++;
        // stall refresh
        vecs[nv] = '{1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0, 1'b1,3'd5,16'h0001, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000,3'd0,3'd0}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd5,3'd3,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0001,16'hBEEF,3'd5,3'd3}; nv++;
        vecs[nv] = '{1'b0,1'b0,3'd0,3'd0,1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0001,16'hBEEF,3'd5,3'd3}; nv++;
        vecs[nv] = '{1'b0,1'b0,3'd0,3'd0,1'b0,1'b1,1'b0, 1'b1,3'd5,16'h00AA, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h00AA,16'hBEEF,3'd5,3'd3}; nv++;
        vecs[nv] = '{1'b0,1'b0,3'd0,3'd0,1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h00AA,16'hBEEF,3'd5,3'd3}; nv++;
        vecs[nv] = '{1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000,3'd0,3'd0}; nv++;
        // flush beats stall, write still lands
        vecs[nv] = '{1'b0,1'b1,3'd5,3'd5,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h00AA,16'h00AA,3'd5,3'd5}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd3,3'd5,1'b0,1'b1,1'b1, 1'b1,3'd6,16'h6666, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000,3'd0,3'd0}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd6,3'd5,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h6666,16'h00AA,3'd6,3'd5}; nv++;
        // input port: bypass, hold, no forwarding on A
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd2,1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,16'h5A5A, 1'b1,16'h5A5A,16'h3333,3'd2,3'd2}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd6,1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'hFFFF, 1'b1,16'h5A5A,16'h6666,3'd2,3'd6}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd2,1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b1,3'd2,16'h7777, 1'b0,3'd0,16'h0000, 1'b0,16'hFFFF, 1'b1,16'h5A5A,16'h7777,3'd2,3'd2}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd2,3'd2,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h3333,16'h3333,3'd2,3'd2}; nv++;
        // index 0 and 7 edges
        vecs[nv] = '{1'b0,1'b1,3'd0,3'd7,1'b0,1'b0,1'b0, 1'b1,3'd0,16'h0F0F, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0F0F,16'h0000,3'd0,3'd7}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd7,3'd0,1'b0,1'b0,1'b0, 1'b1,3'd7,16'h7007, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h7007,16'h0F0F,3'd7,3'd0}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd7,3'd7,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h7007,16'h7007,3'd7,3'd7}; nv++;
        // reset mid-stall clears array, input port and held instruction
        vecs[nv] = '{1'b0,1'b1,3'd6,3'd7,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h6666,16'h7007,3'd6,3'd7}; nv++;
        vecs[nv] = '{1'b1,1'b1,3'd6,3'd7,1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000,3'd0,3'd0}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd6,3'd7,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0000,16'h0000,3'd6,3'd7}; nv++;
        vecs[nv] = '{1'b0,1'b1,3'd0,3'd0,1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0000,16'h0000,3'd0,3'd0}; nv++;

        for (int i = 0; i < nv; i++) begin
            step($sformatf("row%0d", i), vecs[i]);
        end

        // Hand sequence: forwards during stall, then held a_sel with port capture.
        v = '0; v.idv = 1'b1; v.rs = 3'd1; v.rt = 3'd4;
        v.e_valid = 1'b1; v.e_rs = 3'd1; v.e_rt = 3'd4;
        step("seq capture", v);

        v = '0; v.stall = 1'b1;
        v.ex_en = 1'b1; v.ex_addr = 3'd1; v.ex_data = 16'hE1E1;
        v.mem_en = 1'b1; v.mem_addr = 3'd4; v.mem_data = 16'h0404;
        v.e_valid = 1'b1; v.e_a = 16'hE1E1; v.e_b = 16'h0404; v.e_rs = 3'd1; v.e_rt = 3'd4;
        step("seq stall fwd", v);

        v = '0; v.stall = 1'b1;
        v.e_valid = 1'b1; v.e_rs = 3'd1; v.e_rt = 3'd4;
        step("seq stall nofwd", v);

        v = '0; v.idv = 1'b1; v.asel = 1'b1; v.rt = 3'd1;
        v.ip_en = 1'b1; v.ip_data = 16'h1234;
        v.e_valid = 1'b1; v.e_a = 16'h1234; v.e_rt = 3'd1;
        step("seq port capture", v);

        v = '0; v.stall = 1'b1; v.ip_en = 1'b1; v.ip_data = 16'hCAFE;
        v.e_valid = 1'b1; v.e_a = 16'hCAFE; v.e_rt = 3'd1;
        step("seq stall port", v);

        v = '0; v.stall = 1'b1; v.ip_data = 16'h0BAD;
        v.e_valid = 1'b1; v.e_a = 16'hCAFE; v.e_rt = 3'd1;
        step("seq stall held asel", v);

        v = '0; v.flush = 1'b1; v.idv = 1'b1; v.rs = 3'd3;
        step("seq flush", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Decode-side consumer of the write-back bus. It holds the 8×16 general-purpose register file written by the write-back stage and reads two source operands per instruction. It resolves read-after-write hazards by forwarding from the EX/MEM and MEM/WB pipeline points and by same-cycle write-back bypass. It registers the operands into the ID/EX boundary with stall and flush control, and latches the external input port, which is the counterpart of the write-back output port.

## Interface
Parameters:
- DATA_W, 16, operand/register width
- REG_COUNT, 8, number of general-purpose registers
- ADDR_W, 3, register address width (log2 REG_COUNT)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- rs_addr  in  ADDR_W  source A register index
- rt_addr  in  ADDR_W  source B register index
- a_sel_in  in  1  operand A comes from the input-port register instead of rs
- stall  in  1  hold ID/EX boundary
- flush  in  1  insert bubble at ID/EX boundary
- wb_en  in  1  write-back write enable
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back data (selected imm/alu/mem value)
- ex_fwd_en, ex_fwd_addr, ex_fwd_data  in  1/ADDR_W/DATA_W  EX/MEM result in flight
- mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1/ADDR_W/DATA_W  MEM/WB result in flight
- in_port_en  in  1  capture in_port_data
- in_port_data  in  DATA_W  external input port
- op_valid  out  1  op_a/op_b valid for EX
- op_a, op_b  out  DATA_W  registered operands
- op_rs, op_rt  out  ADDR_W  registered source indices (for EX-side hazard logic)

## Operation
- Register file: REG_COUNT×DATA_W. Write on edge when wb_en. All registers are general purpose; there is no hardwired zero.
- Source value resolution per operand, highest priority first:
  1. ex_fwd (en && addr match)
  2. mem_fwd
  3. wb bypass (wb_en && wb_addr match)
  4. array contents
- Operand A with a_sel_in=1: the input-port register, or in_port_data when in_port_en is high in the same cycle (bypass). No forwarding applies.
- Input-port register: loads in_port_data on edge when in_port_en. Holds otherwise, including during stall.
- ID/EX boundary, evaluated at each edge in priority order:
  - rst: all state cleared.
  - flush: op_valid←0, op_a/op_b/op_rs/op_rt←0. Flush beats stall.
  - stall: op_valid, op_rs, op_rt and the latched a_sel_in hold. op_a/op_b are re-resolved from the held indices through the same priority mux, so writes or forwards arriving during a stall are picked up. A held operand never goes stale.
  - Otherwise: capture id_valid, rs/rt, a_sel_in and the resolved values.
- Register-file writes are never blocked by stall or flush.

## Timing
- Reset: register array, input-port register, op_valid, op_a, op_b, op_rs and op_rt are all 0 after the first rst edge. rst held over multiple edges keeps everything 0. rst mid-stall discards the held instruction.
- Latency: 1 cycle from id_valid/rs/rt to op_valid/op_a/op_b.
- Write-to-read: a wb write in cycle N is visible to a decode read in cycle N through the bypass. It is in the array from cycle N+1.
- Multiple sources matching the same index: the priority order above; youngest data wins.
- Indices of 0 and REG_COUNT-1 behave identically to all others. The address width is exact, so no out-of-range case exists.

## Structure
- Shared package: DATA_W, ADDR_W and REG_COUNT constants; a fwd_src_t enum (FWD_EX, FWD_MEM, FWD_WB, FWD_RF) exposed for debug/coverage.
- One sub-module, operand_resolver: combinational priority mux, instantiated twice (A, B). The top holds the register array, input-port register and ID/EX registers.

## Test plan
- Reset then read all: rst 1 cycle, read rs=0..7 → op_a=op_b=0x0000, op_valid=0 during rst, then 1 one cycle after id_valid.
- WB bypass: wb_en, wb_addr=3, wb_data=0xBEEF with rs=3 in the same cycle → op_a=0xBEEF next cycle. A later read of R3 with no forwarding → 0xBEEF.
- Forward priority: ex_fwd R2=0x1111, mem_fwd R2=0x2222, wb R2=0x3333, rs=rt=2 → op_a=op_b=0x1111. Drop ex_fwd → 0x2222. Drop mem_fwd → 0x3333.
- Stall refresh: capture rs=5 (R5=0x0001), assert stall 3 cycles, wb R5=0x00AA in stall cycle 2 → op_valid held 1, op_a=0x00AA from the following edge, op_rs stays 5.
- Flush vs stall: stall=flush=1 with a valid instruction → op_valid=0, op_a=op_b=0. A wb write in the same cycle still lands (read next → written value).
- Input port: in_port_en with 0x5A5A and a_sel_in=1 in the same cycle → op_a=0x5A5A. Deassert in_port_en, drive 0xFFFF → op_a stays 0x5A5A.
